// File: rtl/seg7_pkg.sv
// Shared segment types and glyph constants for the single-digit 7-segment decoder.
// Segment vectors are ordered ABCDEFG with A in bit 6.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_lut.sv
// Combinational value-to-glyph map, always in active-high polarity.
// In BCD mode codes 10..15 blank the digit and light DP as an error flag.
module seg7_lut
    import seg7_pkg::*;
#(
    parameter int unsigned HEX_MODE = 0
) (
    input  logic [3:0] value,
    output seg_t       segments,
    output logic       dp
);

    always_comb begin
        segments = SEG_BLANK;
        dp       = 1'b0;
        case (value)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
            default: segments = SEG_BLANK;
        endcase
        if (HEX_MODE == 0 && value > 4'd9) begin
            segments = SEG_BLANK;
            dp       = 1'b1;
        end
    end

endmodule

// File: rtl/seg7_decoder.sv
// Registered single-digit 7-segment decoder: one cycle of latency from {a,b,c,d}
// to the segment pins, with optional active-low segment/DP polarity.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned HEX_MODE       = 0,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F,
    output logic G,
    output logic DP,
    output logic W
);

    // XOR mask applied to {A..G, DP}; W is deliberately excluded.
    localparam logic [7:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    seg_t       segments;
    logic       dp;
    logic [7:0] pins_q;
    logic       enable_q;

    seg7_lut #(
        .HEX_MODE(HEX_MODE)
    ) u_lut (
        .value   ({a, b, c, d}),
        .segments(segments),
        .dp      (dp)
    );

    // Reset blanks the digit at its unlit level, which depends on polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            pins_q   <= POL_MASK;
            enable_q <= 1'b0;
        end else begin
            pins_q   <= {segments, dp} ^ POL_MASK;
            enable_q <= 1'b1;
        end
    end

    assign {A, B, C, D, E, F, G, DP} = pins_q;
    assign W = enable_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed self-checking bench: four decoder instances (BCD/hex x active-high/low)
// share the same inputs and are compared each cycle against a hand-written glyph table.
module tb_seg7_decoder;

    logic clk;
    logic rst;
    logic a, b, c, d;

    logic [8:0] bcd_out;
    logic [8:0] hex_out;
    logic [8:0] low_out;
    logic [8:0] hexlow_out;

    int vectors_applied = 0;
    int miscompares     = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    seg7_decoder #(.HEX_MODE(0), .SEG_ACTIVE_LOW(0)) u_bcd (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .A(bcd_out[8]), .B(bcd_out[7]), .C(bcd_out[6]), .D(bcd_out[5]),
        .E(bcd_out[4]), .F(bcd_out[3]), .G(bcd_out[2]), .DP(bcd_out[1]), .W(bcd_out[0])
    );

    seg7_decoder #(.HEX_MODE(1), .SEG_ACTIVE_LOW(0)) u_hex (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .A(hex_out[8]), .B(hex_out[7]), .C(hex_out[6]), .D(hex_out[5]),
        .E(hex_out[4]), .F(hex_out[3]), .G(hex_out[2]), .DP(hex_out[1]), .W(hex_out[0])
    );

    seg7_decoder #(.HEX_MODE(0), .SEG_ACTIVE_LOW(1)) u_low (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .A(low_out[8]), .B(low_out[7]), .C(low_out[6]), .D(low_out[5]),
        .E(low_out[4]), .F(low_out[3]), .G(low_out[2]), .DP(low_out[1]), .W(low_out[0])
    );

    seg7_decoder #(.HEX_MODE(1), .SEG_ACTIVE_LOW(1)) u_hexlow (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .A(hexlow_out[8]), .B(hexlow_out[7]), .C(hexlow_out[6]), .D(hexlow_out[5]),
        .E(hexlow_out[4]), .F(hexlow_out[3]), .G(hexlow_out[2]), .DP(hexlow_out[1]), .W(hexlow_out[0])
    );

    // Reference glyphs in ABCDEFG order, active-high.
    function automatic logic [6:0] refGlyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [8:0] refOut(input logic [3:0] v, input logic r,
                                          input bit hex, input bit low);
        logic [6:0] seg;
        logic       dp;
        logic       w;
        if (r) begin
            seg = 7'b0000000;
            dp  = 1'b0;
            w   = 1'b0;
        end else if (!hex && v > 4'd9) begin
            seg = 7'b0000000;
            dp  = 1'b1;
            w   = 1'b1;
        end else begin
            seg = refGlyph(v);
            dp  = 1'b0;
            w   = 1'b1;
        end
        if (low) begin
            seg = ~seg;
            dp  = ~dp;
        end
        return {seg, dp, w};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got ABCDEFG_DP_W=%b required %b", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string note, input logic [3:0] v, input logic r);
        checkOutput($sformatf("%s bcd v=%0d rst=%0b", note, v, r), bcd_out, refOut(v, r, 1'b0, 1'b0));
        checkOutput($sformatf("%s hex v=%0d rst=%0b", note, v, r), hex_out, refOut(v, r, 1'b1, 1'b0));
        checkOutput($sformatf("%s low v=%0d rst=%0b", note, v, r), low_out, refOut(v, r, 1'b0, 1'b1));
        checkOutput($sformatf("%s hexlow v=%0d rst=%0b", note, v, r), hexlow_out, refOut(v, r, 1'b1, 1'b1));
    endtask

    // Drive between edges, then check just after the edge that captured the value.
    task automatic applyStimulus(input string note, input logic [3:0] v, input logic r);
        @(negedge clk);
        {a, b, c, d} = v;
        rst = r;
        @(posedge clk);
        #1;
        checkAll(note, v, r);
    endtask

    initial begin
        rst = 1'b1;
        {a, b, c, d} = 4'h8;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 4'h8, 1'b1);
        applyStimulus("release", 4'h8, 1'b0);

        for (int i = 0; i < 16; i++) applyStimulus("sweep", 4'(i), 1'b0);
        applyStimulus("recover", 4'h3, 1'b0);

        // A mid-cycle input change must not reach the outputs before the next edge.
        applyStimulus("preglitch", 4'h5, 1'b0);
        {a, b, c, d} = 4'hE;
        #4;
        checkAll("glitch", 4'h5, 1'b0);

        applyStimulus("low", 4'h1, 1'b0);
        applyStimulus("lowreset", 4'h1, 1'b1);
        applyStimulus("lowrelease", 4'h0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            logic [3:0] v;
            v = 4'(i);
            applyStimulus("toggle", v, (i == 25) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
